// File: rtl/phase_generator_pkg.sv
// rtl/phase_generator_pkg.sv - shared constants and FSM state type for the phase generator
// Purpose: operator count, field widths and sweep FSM encoding used by
// the phase generator, its register-file interface and the increment calculator.
package phase_generator_pkg;

  localparam int NUM_OPERATORS    = 18;
  localparam int PHASE_ACC_WIDTH  = 20;
  localparam int OP_NUM_WIDTH     = 5;
  localparam int REG_FNUM_WIDTH   = 10;
  localparam int REG_BLOCK_WIDTH  = 3;
  localparam int REG_MULT_WIDTH   = 4;
  localparam int PHASE_OUT_WIDTH  = 10;
  localparam int INC_WIDTH        = 20;

  // Cycles spent after the last op_sel while the read/align pipeline empties.
  localparam int DRAIN_CYCLES     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/phase_generator_if.sv
// rtl/phase_generator_if.sv - register-file read bus and phase output stream
// Purpose: bundles the operator register read (op_sel out, fields back one
// cycle later, vib_val two cycles later) and the per-operator phase stream.
// Ports (master = phase generator):
//   op_sel                          out  operator index presented to the register file
//   fnum, block, mult, vib, key_on  in   operator fields, 1 cycle after op_sel
//   vib_val                         in   vibrato offset, 2 cycles after op_sel
//   phase_valid, phase_op, phase    out  one strobe per operator with its phase
interface phase_generator_if;
  import phase_generator_pkg::*;

  logic [OP_NUM_WIDTH-1:0]    op_sel;
  logic [REG_FNUM_WIDTH-1:0]  fnum;
  logic [REG_BLOCK_WIDTH-1:0] block;
  logic [REG_MULT_WIDTH-1:0]  mult;
  logic                       vib;
  logic                       key_on;
  logic [REG_FNUM_WIDTH-1:0]  vib_val;

  logic                       phase_valid;
  logic [OP_NUM_WIDTH-1:0]    phase_op;
  logic [PHASE_OUT_WIDTH-1:0] phase;

  modport master (
    output op_sel, phase_valid, phase_op, phase,
    input  fnum, block, mult, vib, key_on, vib_val
  );

  modport slave (
    input  op_sel, phase_valid, phase_op, phase,
    output fnum, block, mult, vib, key_on, vib_val
  );

endinterface

// File: rtl/phase_inc_calc.sv
// rtl/phase_inc_calc.sv - combinational phase increment from F-number, block and multiple
// Purpose: inc = ((feff << block) * mult2) >> 2, mult2 being the doubled
// OPL2 multiple so the half-step for code 0 stays integral.
// Ports:
//   feff   in   effective F-number (vibrato already applied)
//   block  in   octave shift
//   mult   in   multiple code 0..15
//   inc    out  per-sample accumulator increment
module phase_inc_calc
  import phase_generator_pkg::*;
(
  input  logic [REG_FNUM_WIDTH-1:0]  feff,
  input  logic [REG_BLOCK_WIDTH-1:0] block,
  input  logic [REG_MULT_WIDTH-1:0]  mult,
  output logic [INC_WIDTH-1:0]       inc
);

  logic [4:0]  mult2;
  logic [16:0] shifted;
  logic [21:0] product;

  always_comb begin
    case (mult)
      4'd0:    mult2 = 5'd1;
      4'd1:    mult2 = 5'd2;
      4'd2:    mult2 = 5'd4;
      4'd3:    mult2 = 5'd6;
      4'd4:    mult2 = 5'd8;
      4'd5:    mult2 = 5'd10;
      4'd6:    mult2 = 5'd12;
      4'd7:    mult2 = 5'd14;
      4'd8:    mult2 = 5'd16;
      4'd9:    mult2 = 5'd18;
      4'd10:   mult2 = 5'd20;
      4'd11:   mult2 = 5'd20;
      4'd12:   mult2 = 5'd24;
      4'd13:   mult2 = 5'd24;
      4'd14:   mult2 = 5'd30;
      default: mult2 = 5'd30;
    endcase

    shifted = {7'd0, feff} << block;
    product = 22'(shifted) * 22'(mult2);
    // Worst case 0x3FF<<7 * 30 / 4 = 0xEFC40 still fits 20 bits.
    inc     = INC_WIDTH'(product >> 2);
  end

endmodule

// File: rtl/phase_generator.sv
// rtl/phase_generator.sv - time-multiplexed 18-operator phase accumulator
// Purpose: on each sample tick, sweeps every operator through the register
// file, applies vibrato to the F-number, advances that operator's 20-bit
// accumulator and streams its top 10 bits out with a valid strobe.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   sample_clk_en  in   one-cycle tick starting a sweep
//   pif            master side of phase_generator_if (register read + phase stream)
//   busy           out  sweep in progress (RUN or DRAIN)
//   overrun        out  sticky: tick seen while busy, cleared only by reset
module phase_generator
  import phase_generator_pkg::*;
#(
  parameter int NUM_OPS = NUM_OPERATORS,
  parameter int ACC_W   = PHASE_ACC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk_en,
  phase_generator_if.master   pif,
  output logic                busy,
  output logic                overrun
);

  // Sweep FSM
  state_t                    state_q, state_d;
  logic [OP_NUM_WIDTH-1:0]   cnt_q, cnt_d;
  logic                      overrun_q, overrun_d;
  logic [OP_NUM_WIDTH-1:0]   op_sel_w;

  // Stage 1: op index in flight while the register file answers
  logic                      s1_valid_q, s1_valid_d;
  logic [OP_NUM_WIDTH-1:0]   s1_op_q, s1_op_d;

  // Stage 2: fields registered so they line up with vib_val
  logic                      s2_valid_q, s2_valid_d;
  logic [OP_NUM_WIDTH-1:0]   s2_op_q, s2_op_d;
  logic [REG_FNUM_WIDTH-1:0] s2_fnum_q, s2_fnum_d;
  logic [REG_BLOCK_WIDTH-1:0] s2_block_q, s2_block_d;
  logic [REG_MULT_WIDTH-1:0] s2_mult_q, s2_mult_d;
  logic                      s2_vib_q, s2_vib_d;
  logic                      s2_key_q, s2_key_d;

  // Per-operator state
  logic [ACC_W-1:0]          acc_q [NUM_OPS];
  logic [ACC_W-1:0]          acc_d [NUM_OPS];
  logic [NUM_OPS-1:0]        key_hist_q, key_hist_d;

  // Output registers
  logic                      phase_valid_q, phase_valid_d;
  logic [OP_NUM_WIDTH-1:0]   phase_op_q, phase_op_d;
  logic [PHASE_OUT_WIDTH-1:0] phase_q, phase_d;

  // Datapath
  logic [REG_FNUM_WIDTH-1:0] feff;
  logic [INC_WIDTH-1:0]      inc;
  logic                      key_edge;
  logic [ACC_W-1:0]          acc_new;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = (state_q != ST_IDLE);
    op_sel_w  = '0;
    // A tick on the final DRAIN cycle still lands while busy, so it counts too.
    overrun_d = overrun_q | (sample_clk_en & busy);

    case (state_q)
      ST_IDLE: begin
        if (sample_clk_en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        op_sel_w = cnt_q;
        if (cnt_q == OP_NUM_WIDTH'(NUM_OPS - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == OP_NUM_WIDTH'(DRAIN_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Plain 10-bit wrap: a ones-complement negative vib_val yields fnum - delta - 1.
  always_comb begin
    feff = s2_vib_q ? (s2_fnum_q + pif.vib_val) : s2_fnum_q;
  end

  phase_inc_calc u_inc (
    .feff  (feff),
    .block (s2_block_q),
    .mult  (s2_mult_q),
    .inc   (inc)
  );

  always_comb begin
    s1_valid_d = (state_q == ST_RUN);
    s1_op_d    = op_sel_w;

    s2_valid_d = s1_valid_q;
    s2_op_d    = s1_op_q;
    s2_fnum_d  = pif.fnum;
    s2_block_d = pif.block;
    s2_mult_d  = pif.mult;
    s2_vib_d   = pif.vib;
    s2_key_d   = pif.key_on;

    key_edge   = s2_key_q & ~key_hist_q[s2_op_q];
    acc_new    = key_edge ? '0 : (acc_q[s2_op_q] + ACC_W'(inc));

    acc_d         = acc_q;
    key_hist_d    = key_hist_q;
    phase_valid_d = s2_valid_q;
    phase_op_d    = phase_op_q;
    phase_d       = phase_q;

    if (s2_valid_q) begin
      acc_d[s2_op_q]      = acc_new;
      key_hist_d[s2_op_q] = s2_key_q;
      phase_op_d          = s2_op_q;
      phase_d             = acc_new[ACC_W-1 -: PHASE_OUT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_op_q       <= '0;
      s2_fnum_q     <= '0;
      s2_block_q    <= '0;
      s2_mult_q     <= '0;
      s2_vib_q      <= 1'b0;
      s2_key_q      <= 1'b0;
      acc_q         <= '{default: '0};
      key_hist_q    <= '0;
      phase_valid_q <= 1'b0;
      phase_op_q    <= '0;
      phase_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s2_valid_q    <= s2_valid_d;
      s2_op_q       <= s2_op_d;
      s2_fnum_q     <= s2_fnum_d;
      s2_block_q    <= s2_block_d;
      s2_mult_q     <= s2_mult_d;
      s2_vib_q      <= s2_vib_d;
      s2_key_q      <= s2_key_d;
      acc_q         <= acc_d;
      key_hist_q    <= key_hist_d;
      phase_valid_q <= phase_valid_d;
      phase_op_q    <= phase_op_d;
      phase_q       <= phase_d;
    end
  end

  assign pif.op_sel      = op_sel_w;
  assign pif.phase_valid = phase_valid_q;
  assign pif.phase_op    = phase_op_q;
  assign pif.phase       = phase_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_phase_generator.sv
// tb/tb_phase_generator.sv - self-checking bench for phase_generator
module tb_phase_generator;
  import phase_generator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sample_clk_en;
  logic busy;
  logic overrun;

  phase_generator_if pif ();

  phase_generator #(.NUM_OPS(18), .ACC_W(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_clk_en (sample_clk_en),
    .pif           (pif),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0]  cfg_fnum [18];
  logic [9:0]  cfg_vv   [18];
  logic [2:0]  cfg_blk  [18];
  logic [3:0]  cfg_mult [18];
  logic        cfg_vib  [18];
  logic        cfg_key  [18];

  logic [19:0] m_acc     [18];
  logic        m_key     [18];
  logic [9:0]  obs_phase [18];

  typedef struct packed {
    logic [4:0] op;
    logic [9:0] ph;
  } exp_t;
  exp_t sbq [$];

  // Register file: fields one cycle after op_sel, vib_val two cycles after.
  initial begin
    int cur;
    int prev;
    cur = 0;
    prev = 0;
    pif.fnum = '0; pif.block = '0; pif.mult = '0;
    pif.vib = 1'b0; pif.key_on = 1'b0; pif.vib_val = '0;
    forever begin
      @(negedge clk);
      cur = int'(pif.op_sel);
      if (cur > 17) cur = 0;
      @(posedge clk);
      #1;
      pif.fnum    = cfg_fnum[cur];
      pif.block   = cfg_blk[cur];
      pif.mult    = cfg_mult[cur];
      pif.vib     = cfg_vib[cur];
      pif.key_on  = cfg_key[cur];
      pif.vib_val = cfg_vv[prev];
      prev = cur;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_inc(input logic [9:0] feff, input logic [2:0] blk,
                                            input logic [3:0] mult);
    logic [4:0]  m2;
    logic [21:0] p;
    case (mult)
      4'd0: m2 = 5'd1;   4'd1: m2 = 5'd2;   4'd2: m2 = 5'd4;   4'd3: m2 = 5'd6;
      4'd4: m2 = 5'd8;   4'd5: m2 = 5'd10;  4'd6: m2 = 5'd12;  4'd7: m2 = 5'd14;
      4'd8: m2 = 5'd16;  4'd9: m2 = 5'd18;  4'd10: m2 = 5'd20; 4'd11: m2 = 5'd20;
      4'd12: m2 = 5'd24; 4'd13: m2 = 5'd24; default: m2 = 5'd30;
    endcase
    p = (22'(feff) << blk) * 22'(m2);
    return p[21:2];
  endfunction

  task automatic push_expected();
    logic [9:0]  feff;
    logic [19:0] inc;
    for (int op = 0; op < 18; op++) begin
      feff = cfg_vib[op] ? (cfg_fnum[op] + cfg_vv[op]) : cfg_fnum[op];
      inc  = model_inc(feff, cfg_blk[op], cfg_mult[op]);
      if (!m_key[op] && cfg_key[op]) m_acc[op] = '0;
      else m_acc[op] = m_acc[op] + inc;
      m_key[op] = cfg_key[op];
      sbq.push_back({5'(op), m_acc[op][19:10]});
    end
  endtask

  task automatic model_reset();
    for (int op = 0; op < 18; op++) begin
      m_acc[op] = '0;
      m_key[op] = 1'b0;
    end
    sbq.delete();
  endtask

  task automatic set_all(input logic [9:0] fnum, input logic [2:0] blk, input logic [3:0] mult,
                         input logic vib, input logic [9:0] vv, input logic key);
    for (int op = 0; op < 18; op++) begin
      cfg_fnum[op] = fnum; cfg_blk[op] = blk; cfg_mult[op] = mult;
      cfg_vib[op] = vib;   cfg_vv[op] = vv;   cfg_key[op] = key;
    end
  endtask

  task automatic run_sweep(input bit extra_tick);
    int   nvalid;
    exp_t e;
    push_expected();
    @(negedge clk);
    sample_clk_en = 1'b1;
    @(negedge clk);
    sample_clk_en = 1'b0;
    nvalid = 0;
    for (int n = 1; n <= 24; n++) begin
      if (n > 1) @(negedge clk);
      if (extra_tick) sample_clk_en = (n == 5);
      if (n == 1)  chk("busy_start", 32'(busy), 32'd1);
      if (n <= 18) chk("op_sel_run", 32'(pif.op_sel), 32'(n - 1));
      else         chk("op_sel_idle", 32'(pif.op_sel), 32'd0);
      if (n == 21) chk("busy_last", 32'(busy), 32'd1);
      if (n == 22) chk("busy_fall", 32'(busy), 32'd0);
      if (pif.phase_valid) begin
        nvalid++;
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("phase_op", 32'(pif.phase_op), 32'(e.op));
          chk("phase", 32'(pif.phase), 32'(e.ph));
          chk("latency", 32'(n), 32'(e.op) + 32'd4);
          obs_phase[e.op] = pif.phase;
        end
      end
    end
    sample_clk_en = 1'b0;
    chk("valid_count", 32'(nvalid), 32'd18);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int nv;
    rst_n = 1'b0;
    sample_clk_en = 1'b0;
    set_all(10'h200, 3'd4, 4'd1, 1'b0, 10'h000, 1'b1);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_op_sel", 32'(pif.op_sel), 32'd0);
    chk("rst_phase_valid", 32'(pif.phase_valid), 32'd0);
    chk("rst_phase_op", 32'(pif.phase_op), 32'd0);
    chk("rst_phase", 32'(pif.phase), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First sweep with key 1 after reset is an edge: everything starts at 0.
    run_sweep(1'b0);
    chk("prime_op0", 32'(obs_phase[0]), 32'h000);
    run_sweep(1'b0);
    chk("basic_op0", 32'(obs_phase[0]), 32'h004);
    chk("basic_op17", 32'(obs_phase[17]), 32'h004);
    run_sweep(1'b0);
    chk("basic2_op0", 32'(obs_phase[0]), 32'h008);
    repeat (254) run_sweep(1'b0);
    chk("wrap_op3", 32'(obs_phase[3]), 32'h000);

    // Key-on edge on op 5 after three key-off sweeps.
    cfg_key[5] = 1'b0;
    repeat (3) run_sweep(1'b0);
    cfg_key[5] = 1'b1;
    run_sweep(1'b0);
    chk("edge_op5", 32'(obs_phase[5]), 32'h000);
    chk("edge_op4", 32'(obs_phase[4]), 32'h010);
    run_sweep(1'b0);
    chk("after_edge_op5", 32'(obs_phase[5]), 32'h004);
    chk("after_edge_op4", 32'(obs_phase[4]), 32'h014);

    // Tick during RUN is ignored but flagged.
    chk("overrun_before", 32'(overrun), 32'd0);
    run_sweep(1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    run_sweep(1'b0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-sweep.
    @(negedge clk);
    sample_clk_en = 1'b1;
    @(negedge clk);
    sample_clk_en = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_op_sel", 32'(pif.op_sel), 32'd0);
    chk("midrst_phase_valid", 32'(pif.phase_valid), 32'd0);
    chk("midrst_phase_op", 32'(pif.phase_op), 32'd0);
    chk("midrst_phase", 32'(pif.phase), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (pif.phase_valid) nv++;
    end
    chk("no_partial_out", 32'(nv), 32'd0);
    model_reset();

    // Vibrato and table extremes, key off so accumulators start from 0.
    set_all(10'h200, 3'd0, 4'd1, 1'b0, 10'h000, 1'b0);
    cfg_vib[1] = 1'b1; cfg_vv[1] = 10'h004;
    cfg_vib[2] = 1'b0; cfg_vv[2] = 10'h004;
    cfg_vib[6] = 1'b1; cfg_vv[6] = 10'h3FB; cfg_blk[6] = 3'd7;
    cfg_fnum[7] = 10'h000; cfg_vib[7] = 1'b1; cfg_vv[7] = 10'h3FF; cfg_blk[7] = 3'd7;
    cfg_fnum[8] = 10'h3FF; cfg_blk[8] = 3'd7; cfg_mult[8] = 4'd0;
    cfg_fnum[9] = 10'h3FF; cfg_blk[9] = 3'd7; cfg_mult[9] = 4'd15;
    run_sweep(1'b0);
    chk("vib_neg_op6", 32'(obs_phase[6]), 32'h01F);
    chk("vib_wrap_op7", 32'(obs_phase[7]), 32'h03F);
    chk("mult0_op8", 32'(obs_phase[8]), 32'h01F);
    chk("mult15_op9", 32'(obs_phase[9]), 32'h3BF);
    repeat (3) run_sweep(1'b0);
    chk("mult15_x4_op9", 32'(obs_phase[9]), 32'h2FC);
    chk("overrun_after_rst", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
